// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: allocates entries at the tail, captures CDB results by tag,
// retires in program order from the head, and clears everything on a mispredicted branch.
module rob_ctrl #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PTR_W  = 3,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [3:0]        alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic [PTR_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [PTR_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispredict,
    output logic              commit_valid,
    output logic              commit_we,
    output logic              commit_store,
    output logic [REG_W-1:0]  commit_rd,
    output logic [PTR_W-1:0]  commit_tag,
    output logic [DATA_W-1:0] commit_data,
    output logic              flush,
    output logic              cdb_err,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] CountFull = (PTR_W + 1)'(DEPTH);
    localparam logic [3:0]     FnStore   = 4'b0101;

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEPTH-1:0]  mispred_q, mispred_d;
    logic [3:0]        func_q [DEPTH];
    logic [3:0]        func_d [DEPTH];
    logic [REG_W-1:0]  rd_q [DEPTH];
    logic [REG_W-1:0]  rd_d [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              cdb_err_q, cdb_err_d;

    logic       alloc_fire;
    logic       cdb_hit;
    logic       head_branch;
    logic [3:0] head_func;

    // Retire-side decode, all from registered state.
    always_comb begin
        head_func    = func_q[head_q];
        head_branch  = (head_func[3:1] == 3'b011);
        commit_valid = busy_q[head_q] & done_q[head_q];
        flush        = commit_valid & head_branch & mispred_q[head_q];
        commit_we    = commit_valid & ~head_func[3] & (head_func[2:0] <= 3'd4);
        commit_store = commit_valid & (head_func == FnStore);
        commit_rd    = commit_valid ? rd_q[head_q] : '0;
        commit_tag   = commit_valid ? head_q : '0;
        commit_data  = commit_valid ? value_q[head_q] : '0;
        alloc_ready  = (count_q != CountFull) && !flush;
        alloc_fire   = alloc_valid & alloc_ready;
        alloc_tag    = tail_q;
        cdb_hit      = busy_q[cdb_tag] & ~done_q[cdb_tag];
        cdb_err      = cdb_err_q;
        count        = count_q;
    end

    always_comb begin
        busy_d    = busy_q;
        done_d    = done_q;
        mispred_d = mispred_q;
        func_d    = func_q;
        rd_d      = rd_q;
        value_d   = value_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        cdb_err_d = 1'b0;
        if (flush) begin
            // Whole buffer is squashed; a same-cycle CDB is dropped silently.
            busy_d    = '0;
            done_d    = '0;
            mispred_d = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end else begin
            if (commit_valid) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
            end
            if (alloc_fire) begin
                busy_d[tail_q]    = 1'b1;
                done_d[tail_q]    = 1'b0;
                mispred_d[tail_q] = 1'b0;
                func_d[tail_q]    = alloc_func;
                rd_d[tail_q]      = alloc_rd;
                tail_d            = tail_q + 1'b1;
            end
            // Hit test uses registered busy, so a CDB to a same-cycle allocation is an error.
            if (cdb_valid) begin
                if (cdb_hit) begin
                    done_d[cdb_tag]    = 1'b1;
                    value_d[cdb_tag]   = cdb_data;
                    mispred_d[cdb_tag] = cdb_mispredict;
                end else begin
                    cdb_err_d = 1'b1;
                end
            end
            count_d = count_q + {{PTR_W{1'b0}}, alloc_fire} - {{PTR_W{1'b0}}, commit_valid};
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            busy_q    <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            func_q    <= '{default: '0};
            rd_q      <= '{default: '0};
            value_q   <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            cdb_err_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            mispred_q <= mispred_d;
            func_q    <= func_d;
            rd_q      <= rd_d;
            value_q   <= value_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            cdb_err_q <= cdb_err_d;
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: allocation, out-of-order CDB, in-order retire, wrap, flush,
// CDB error pulses and mid-operation reset, each against hand-computed values.
module tb_rob_ctrl;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_func;
    logic [3:0]  alloc_rd;
    logic [2:0]  alloc_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        cdb_mispredict;
    logic        commit_valid;
    logic        commit_we;
    logic        commit_store;
    logic [3:0]  commit_rd;
    logic [2:0]  commit_tag;
    logic [15:0] commit_data;
    logic        flush;
    logic        cdb_err;
    logic [3:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    rob_ctrl #(.DEPTH(8), .PTR_W(3), .DATA_W(16), .REG_W(4)) dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_func     (alloc_func),
        .alloc_rd       (alloc_rd),
        .alloc_tag      (alloc_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_mispredict (cdb_mispredict),
        .commit_valid   (commit_valid),
        .commit_we      (commit_we),
        .commit_store   (commit_store),
        .commit_rd      (commit_rd),
        .commit_tag     (commit_tag),
        .commit_data    (commit_data),
        .flush          (flush),
        .cdb_err        (cdb_err),
        .count          (count)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run mid-cycle.
    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        alloc_valid    = 1'b0;
        alloc_func     = 4'h0;
        alloc_rd       = 4'h0;
        cdb_valid      = 1'b0;
        cdb_tag        = 3'd0;
        cdb_data       = 16'h0;
        cdb_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_alloc(input logic [3:0] f, input logic [3:0] rd);
        alloc_valid = 1'b1;
        alloc_func  = f;
        alloc_rd    = rd;
    endtask

    task automatic set_cdb(input logic [2:0] t, input logic [15:0] d, input logic mp);
        cdb_valid      = 1'b1;
        cdb_tag        = t;
        cdb_data       = d;
        cdb_mispredict = mp;
    endtask

    initial begin
        do_reset();

        // T1: reset state, then alloc -> CDB -> commit latency
        settle();
        check("rst_count", 32'(count), 0);
        check("rst_alloc_ready", 32'(alloc_ready), 1);
        check("rst_commit_valid", 32'(commit_valid), 0);
        check("rst_commit_we", 32'(commit_we), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_cdb_err", 32'(cdb_err), 0);
        check("rst_alloc_tag", 32'(alloc_tag), 0);
        set_alloc(4'b0000, 4'd3);
        tick();
        idle_inputs();
        set_cdb(3'd0, 16'h0042, 1'b0);
        settle();
        check("t1_n1_commit_valid", 32'(commit_valid), 0);
        check("t1_n1_count", 32'(count), 1);
        tick();
        idle_inputs();
        settle();
        check("t1_commit_valid", 32'(commit_valid), 1);
        check("t1_commit_we", 32'(commit_we), 1);
        check("t1_commit_store", 32'(commit_store), 0);
        check("t1_commit_rd", 32'(commit_rd), 3);
        check("t1_commit_data", 32'(commit_data), 32'h42);
        check("t1_commit_tag", 32'(commit_tag), 0);
        tick();
        settle();
        check("t1_count_after", 32'(count), 0);
        check("t1_commit_after", 32'(commit_valid), 0);

        // T2: fill, out-of-order CDB, in-order retire, no full bypass
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_alloc(4'(i % 4), 4'(i + 1));
            settle();
            check("t2_alloc_tag", 32'(alloc_tag), 32'(i));
            tick();
        end
        idle_inputs();
        settle();
        check("t2_full_ready", 32'(alloc_ready), 0);
        check("t2_full_count", 32'(count), 8);
        set_cdb(3'd5, 16'h0055, 1'b0);
        tick();
        set_cdb(3'd2, 16'h0022, 1'b0);
        settle();
        check("t2_no_commit_5", 32'(commit_valid), 0);
        tick();
        set_cdb(3'd0, 16'h00A0, 1'b0);
        tick();
        idle_inputs();
        set_alloc(4'b0000, 4'd9);
        settle();
        check("t2_c0_valid", 32'(commit_valid), 1);
        check("t2_c0_tag", 32'(commit_tag), 0);
        check("t2_c0_data", 32'(commit_data), 32'hA0);
        check("t2_c0_rd", 32'(commit_rd), 1);
        check("t2_nobypass_ready", 32'(alloc_ready), 0);
        tick();
        idle_inputs();
        settle();
        check("t2_count7", 32'(count), 7);
        check("t2_wait_tag1", 32'(commit_valid), 0);
        check("t2_ready7", 32'(alloc_ready), 1);
        set_cdb(3'd1, 16'h0011, 1'b0);
        tick();
        idle_inputs();
        settle();
        check("t2_c1_valid", 32'(commit_valid), 1);
        check("t2_c1_tag", 32'(commit_tag), 1);
        check("t2_c1_data", 32'(commit_data), 32'h11);
        tick();
        settle();
        check("t2_c2_valid", 32'(commit_valid), 1);
        check("t2_c2_tag", 32'(commit_tag), 2);
        check("t2_c2_data", 32'(commit_data), 32'h22);
        tick();
        settle();
        check("t2_wait_tag3", 32'(commit_valid), 0);
        check("t2_count5", 32'(count), 5);

        // T3: 12 alloc/commit pairs, overlapping commit with the next alloc
        do_reset();
        set_alloc(4'b0100, 4'd0);
        settle();
        check("t3_tag_first", 32'(alloc_tag), 0);
        tick();
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            set_cdb(3'(i % 8), 16'(32'h100 + i), 1'b0);
            settle();
            check("t3_count", 32'(count), 1);
            tick();
            idle_inputs();
            if (i < 11) set_alloc(4'b0100, 4'(i + 1));
            settle();
            check("t3_commit_valid", 32'(commit_valid), 1);
            check("t3_commit_tag", 32'(commit_tag), 32'(i % 8));
            check("t3_commit_data", 32'(commit_data), 32'h100 + 32'(i));
            check("t3_commit_we", 32'(commit_we), 1);
            if (i < 11) check("t3_alloc_tag", 32'(alloc_tag), 32'((i + 1) % 8));
            tick();
        end
        idle_inputs();
        settle();
        check("t3_count_end", 32'(count), 0);
        check("t3_tag_end", 32'(alloc_tag), 4);

        // T4: mispredicted branch flush; same-cycle alloc and CDB are dropped
        do_reset();
        set_alloc(4'b0110, 4'd0);
        tick();
        set_alloc(4'b0010, 4'd5);
        tick();
        idle_inputs();
        set_cdb(3'd1, 16'h0077, 1'b0);
        tick();
        set_cdb(3'd0, 16'h0000, 1'b1);
        settle();
        check("t4_pre_commit", 32'(commit_valid), 0);
        tick();
        idle_inputs();
        set_alloc(4'b0000, 4'd7);
        set_cdb(3'd1, 16'h0099, 1'b0);
        settle();
        check("t4_flush", 32'(flush), 1);
        check("t4_commit_valid", 32'(commit_valid), 1);
        check("t4_commit_we", 32'(commit_we), 0);
        check("t4_ready_blocked", 32'(alloc_ready), 0);
        tick();
        idle_inputs();
        settle();
        check("t4_count", 32'(count), 0);
        check("t4_alloc_tag", 32'(alloc_tag), 0);
        check("t4_no_mul_commit", 32'(commit_valid), 0);
        check("t4_flush_low", 32'(flush), 0);
        check("t4_no_err", 32'(cdb_err), 0);

        // T5: CDB errors (idle tag, already-done tag) and store commit
        do_reset();
        set_cdb(3'd6, 16'h6666, 1'b0);
        tick();
        idle_inputs();
        settle();
        check("t5_err_idle", 32'(cdb_err), 1);
        check("t5_idle_count", 32'(count), 0);
        set_alloc(4'b0001, 4'd2);
        tick();
        set_alloc(4'b0101, 4'd9);
        settle();
        check("t5_err_pulse", 32'(cdb_err), 0);
        tick();
        idle_inputs();
        set_cdb(3'd1, 16'hBEEF, 1'b0);
        tick();
        set_cdb(3'd1, 16'hDEAD, 1'b0);
        settle();
        check("t5_no_err_good", 32'(cdb_err), 0);
        tick();
        set_cdb(3'd0, 16'h0001, 1'b0);
        settle();
        check("t5_err_done", 32'(cdb_err), 1);
        tick();
        idle_inputs();
        settle();
        check("t5_c0_we", 32'(commit_we), 1);
        check("t5_c0_rd", 32'(commit_rd), 2);
        tick();
        settle();
        check("t5_store", 32'(commit_store), 1);
        check("t5_store_we", 32'(commit_we), 0);
        check("t5_store_data", 32'(commit_data), 32'hBEEF);
        tick();
        settle();
        check("t5_count_end", 32'(count), 0);

        // T6: reset with 5 busy entries while head is ready to retire
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(4'b0000, 4'(i));
            tick();
        end
        idle_inputs();
        set_cdb(3'd0, 16'h0abc, 1'b0);
        tick();
        idle_inputs();
        settle();
        check("t6_head_ready", 32'(commit_valid), 1);
        check("t6_count5", 32'(count), 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        check("t6_count", 32'(count), 0);
        check("t6_commit_valid", 32'(commit_valid), 0);
        check("t6_alloc_ready", 32'(alloc_ready), 1);
        check("t6_alloc_tag", 32'(alloc_tag), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
